montador_senha: RTL and testbench
=================================

# montador_senha

Keypad digit assembler for the electronic lock: accepts single decoded key strokes, accumulates up to 20 BCD digits into a packed password word and emits it with a one-cycle `digitos_valid` strobe when the user presses enter. It is the producer side of the `digitos_value`/`digitos_valid` interface consumed by `setup` and the lock's operational FSM; it sits between the keypad decoder and those consumers.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000, inactivity limit in clock cycles before a partial entry is discarded (only with the timeout feature).
- `clk` input 1, system clock; all logic on rising edge.
- `rst` input 1, synchronous, active-high reset.
- `key_value` input 4, key code: 0x0–0x9 digit, 0xA `*` (clear), 0xB `#` (enter), 0xC–0xF ignored.
- `key_valid` input 1, one-cycle strobe qualifying `key_value`.
- `digitos_value` output 80 (`senhaPac_t`), 20 packed BCD digits; digit 0 in [3:0] is the most recently entered; unused positions 0xF.
- `digitos_valid` output 1, one-cycle strobe; `digitos_value` is valid in that cycle.

## Operation
- Internal 80-bit buffer `buf`, 5-bit `count` (0..20), states `VAZIO` (count=0) and `COLETA` (count≥1).
- Reset: state `VAZIO`, `buf` = all 0xF, `count` = 0, `digitos_value` = all 0xF, `digitos_valid` = 0, timeout counter = 0.
- Digit key (0x0–0x9): `buf` <= {buf[75:0], key_value}; `count` <= min(count+1, 20); state → `COLETA`. Beyond 20 digits the oldest digit shifts out (last 20 kept).
- `*` (0xA): `buf` <= all 0xF, `count` <= 0, state → `VAZIO`; no strobe.
- `#` (0xB) in `COLETA`: `digitos_value` <= `buf`, `digitos_valid` <= 1 for exactly one cycle; `buf` <= all 0xF, `count` <= 0, state → `VAZIO`.
- `#` in `VAZIO`: ignored, no strobe, `digitos_value` unchanged.
- Codes 0xC–0xF: ignored entirely (no state change, do not restart timeout).
- `digitos_value` holds the last emitted word until the next emission; it never shows a partial entry.
- `key_value` is don't-care when `key_valid` = 0.

## Timing
- `key_valid` sampled at edge N; buffer/count/state update at edge N; `#` at edge N → `digitos_valid` = 1 during cycle N..N+1, low again after edge N+1.
- A key may arrive every cycle, including the cycle the strobe is high; a digit in that cycle starts a new entry normally.
- Back-to-back `#`, digit, `#` on consecutive cycles → two strobes separated by one low cycle.
- `rst` high at any edge overrides all key activity, including a simultaneous `#` (no strobe).
- Strobe is a pulse; consumer does not acknowledge.

## Configuration
- `MONTADOR_TIMEOUT_EN` defined: counter cleared on every accepted key (0x0–0xB); in `COLETA` increments each cycle without key; on reaching `TIMEOUT_CYCLES`-1 and incrementing, `buf`/`count` cleared, state → `VAZIO`, no strobe. A key in the same cycle as expiry wins (processed, counter cleared). Counter held at 0 in `VAZIO`.
- Not defined: no counter logic; partial entry persists indefinitely.

## Test plan
- Reset, keys 1,2,3,4,# → one strobe, `digitos_value` = {16{4'hF},4'h1,4'h2,4'h3,4'h4}; subsequent cycles strobe 0, value held.
- Keys 1,2,*,5,# → value {19{4'hF},4'h5}; `#` with no digits after reset → no strobe, value all 0xF.
- 22 digits 0,1,…,9,0,…,9,0,1 then # → value holds last 20 digits (2..9,0..9,0,1 order, digit 0 = 1).
- Key 0xD and 0xF interleaved with 7,8,# → value {18{4'hF},4'h7,4'h8}; ignored codes change nothing.
- `rst` asserted in same cycle as `#` after 3 digits → no strobe, outputs at reset values next cycle.
- With `MONTADOR_TIMEOUT_EN`, `TIMEOUT_CYCLES`=10: key 9, idle 10 cycles, # → no strobe; key 9, idle 8 cycles, # → strobe with {19{4'hF},4'h9}.

Source files
------------

// File: rtl/montador_senha_if.sv
// Keypad-to-consumer bus for montador_senha: decoded key strokes in,
// packed BCD password word with a one-cycle strobe out.
interface montador_senha_if;
  logic [3:0]  key_value;
  logic        key_valid;
  logic [79:0] digitos_value;
  logic        digitos_valid;

  modport master (
    output key_value, key_valid,
    input  digitos_value, digitos_valid
  );

  modport slave (
    input  key_value, key_valid,
    output digitos_value, digitos_valid
  );
endinterface

// File: rtl/montador_senha.sv
// Keypad digit assembler: collects up to 20 BCD digits and emits them on enter.
// Optional inactivity timeout enabled by defining MONTADOR_TIMEOUT_EN.
module montador_senha
`ifdef MONTADOR_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 50_000_000)
`endif
  (
    input logic             clk,
    input logic             rst,
    montador_senha_if.slave bus
  );

  typedef enum logic {VAZIO, COLETA} state_t;

  localparam logic [79:0] ALL_F = '1;

  state_t      state, state_n;
  logic [79:0] buffer, buffer_n;
  logic [4:0]  count, count_n;
  logic [79:0] value, value_n;
  logic        valid, valid_n;
`ifdef MONTADOR_TIMEOUT_EN
  logic [31:0] tmo, tmo_n;
`endif

  always_comb begin
    state_n  = state;
    buffer_n = buffer;
    count_n  = count;
    value_n  = value;
    valid_n  = 1'b0;
    if (bus.key_valid) begin
      if (bus.key_value <= 4'h9) begin
        buffer_n = {buffer[75:0], bus.key_value};
        count_n  = (count == 5'd20) ? count : count + 5'd1;
        state_n  = COLETA;
      end else if (bus.key_value == 4'hA) begin
        buffer_n = ALL_F;
        count_n  = '0;
        state_n  = VAZIO;
      end else if (bus.key_value == 4'hB && state == COLETA) begin
        value_n  = buffer;
        valid_n  = 1'b1;
        buffer_n = ALL_F;
        count_n  = '0;
        state_n  = VAZIO;
      end
    end
`ifdef MONTADOR_TIMEOUT_EN
    // An accepted key always wins over a simultaneous expiry.
    tmo_n = tmo;
    if (bus.key_valid && bus.key_value <= 4'hB) begin
      tmo_n = '0;
    end else if (state == COLETA) begin
      if (tmo == TIMEOUT_CYCLES - 1) begin
        buffer_n = ALL_F;
        count_n  = '0;
        state_n  = VAZIO;
        tmo_n    = '0;
      end else begin
        tmo_n = tmo + 32'd1;
      end
    end else begin
      tmo_n = '0;
    end
`else
    // No inactivity limit: a partial entry is kept until * or #.
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= VAZIO;
      buffer <= ALL_F;
      count  <= '0;
      value  <= ALL_F;
      valid  <= 1'b0;
`ifdef MONTADOR_TIMEOUT_EN
      tmo    <= '0;
`endif
    end else begin
      state  <= state_n;
      buffer <= buffer_n;
      count  <= count_n;
      value  <= value_n;
      valid  <= valid_n;
`ifdef MONTADOR_TIMEOUT_EN
      tmo    <= tmo_n;
`endif
    end
  end

  assign bus.digitos_value = value;
  assign bus.digitos_valid = valid;

endmodule

// File: tb/tb_montador_senha.sv
// Self-checking bench for montador_senha against a digit-queue reference model.
module tb_montador_senha;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

`ifdef MONTADOR_TIMEOUT_EN
  localparam int T = 10;
`endif

  montador_senha_if bus ();

`ifdef MONTADOR_TIMEOUT_EN
  montador_senha #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  montador_senha dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending digits in entry order, plus last emitted word.
  logic [3:0]  digits[$];
  logic [79:0] exp_value;
  logic        exp_valid;
  int          idle;

  function automatic logic [79:0] pack_digits();
    logic [79:0] v;
    v = '1;
    for (int i = 0; i < digits.size(); i++)
      v[4*i +: 4] = digits[digits.size() - 1 - i];
    return v;
  endfunction

  function automatic void model_step(input logic r, input logic v, input logic [3:0] k);
    exp_valid = 1'b0;
    if (r) begin
      digits.delete();
      exp_value = '1;
      idle = 0;
      return;
    end
    if (v && k <= 4'h9) begin
      digits.push_back(k);
      if (digits.size() > 20) void'(digits.pop_front());
    end else if (v && k == 4'hA) begin
      digits.delete();
    end else if (v && k == 4'hB && digits.size() > 0) begin
      exp_value = pack_digits();
      exp_valid = 1'b1;
      digits.delete();
    end
`ifdef MONTADOR_TIMEOUT_EN
    if (v && k <= 4'hB) idle = 0;
    else if (digits.size() > 0) begin
      if (idle == T - 1) begin
        digits.delete();
        idle = 0;
      end else idle++;
    end else idle = 0;
`endif
  endfunction

  task automatic apply(input logic r, input logic v, input logic [3:0] k);
    rst = r;
    bus.key_valid = v;
    bus.key_value = k;
    @(posedge clk);
    model_step(r, v, k);
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 4'h0);
    apply(1'b1, 1'b1, 4'h5);
    vectors++;
    if (bus.digitos_valid !== 1'b0 || bus.digitos_value !== {80{1'b1}}) begin
      miscompares++;
      $display("FAIL reset: valid=%b value=%h, expected valid=0 value=%h",
               bus.digitos_valid, bus.digitos_value, {80{1'b1}});
    end
    apply(1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_basic();
    logic [3:0] seq[5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hB};
    foreach (seq[i]) begin
      apply(1'b0, 1'b1, seq[i]);
      vectors++;
      if (bus.digitos_valid !== exp_valid || bus.digitos_value !== exp_value) begin
        miscompares++;
        $display("FAIL basic[%0d]: valid=%b value=%h, expected valid=%b value=%h",
                 i, bus.digitos_valid, bus.digitos_value, exp_valid, exp_value);
      end
    end
    vectors++;
    if (bus.digitos_value !== 80'hFFFF_FFFF_FFFF_FFFF_1234 || bus.digitos_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_word: valid=%b value=%h, expected valid=1 value=%h",
               bus.digitos_valid, bus.digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_1234);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 4'h0);
      vectors++;
      if (bus.digitos_valid !== 1'b0 || bus.digitos_value !== 80'hFFFF_FFFF_FFFF_FFFF_1234) begin
        miscompares++;
        $display("FAIL basic_hold[%0d]: valid=%b value=%h, expected valid=0 value=%h",
                 i, bus.digitos_valid, bus.digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_1234);
      end
    end
  endtask

  task automatic test_clear();
    logic [3:0] seq[5] = '{4'h1, 4'h2, 4'hA, 4'h5, 4'hB};
    foreach (seq[i]) apply(1'b0, 1'b1, seq[i]);
    vectors++;
    if (bus.digitos_valid !== 1'b1 || bus.digitos_value !== 80'hFFFF_FFFF_FFFF_FFFF_FFF5) begin
      miscompares++;
      $display("FAIL clear_word: valid=%b value=%h, expected valid=1 value=%h",
               bus.digitos_valid, bus.digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FFF5);
    end
    // Enter with nothing collected, straight after reset.
    apply(1'b1, 1'b0, 4'h0);
    apply(1'b0, 1'b1, 4'hB);
    vectors++;
    if (bus.digitos_valid !== 1'b0 || bus.digitos_value !== {80{1'b1}}) begin
      miscompares++;
      $display("FAIL empty_enter: valid=%b value=%h, expected valid=0 value=%h",
               bus.digitos_valid, bus.digitos_value, {80{1'b1}});
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 22; i++) apply(1'b0, 1'b1, 4'(i % 10));
    apply(1'b0, 1'b1, 4'hB);
    vectors++;
    if (bus.digitos_valid !== 1'b1 || bus.digitos_value !== 80'h2345_6789_0123_4567_8901) begin
      miscompares++;
      $display("FAIL overflow: valid=%b value=%h, expected valid=1 value=%h",
               bus.digitos_valid, bus.digitos_value, 80'h2345_6789_0123_4567_8901);
    end
  endtask

  task automatic test_ignored();
    logic [3:0] seq[6] = '{4'hD, 4'h7, 4'hF, 4'h8, 4'hC, 4'hB};
    foreach (seq[i]) begin
      apply(1'b0, 1'b1, seq[i]);
      vectors++;
      if (bus.digitos_valid !== exp_valid || bus.digitos_value !== exp_value) begin
        miscompares++;
        $display("FAIL ignored[%0d]: valid=%b value=%h, expected valid=%b value=%h",
                 i, bus.digitos_valid, bus.digitos_value, exp_valid, exp_value);
      end
    end
    vectors++;
    if (bus.digitos_value !== 80'hFFFF_FFFF_FFFF_FFFF_FF78) begin
      miscompares++;
      $display("FAIL ignored_word: value=%h, expected %h",
               bus.digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FF78);
    end
  endtask

  task automatic test_reset_collision();
    apply(1'b0, 1'b1, 4'h3);
    apply(1'b0, 1'b1, 4'h1);
    apply(1'b0, 1'b1, 4'h4);
    apply(1'b1, 1'b1, 4'hB);
    vectors++;
    if (bus.digitos_valid !== 1'b0 || bus.digitos_value !== {80{1'b1}}) begin
      miscompares++;
      $display("FAIL reset_collision: valid=%b value=%h, expected valid=0 value=%h",
               bus.digitos_valid, bus.digitos_value, {80{1'b1}});
    end
    apply(1'b0, 1'b1, 4'hB);
    vectors++;
    if (bus.digitos_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flushed: valid=%b, expected valid=0", bus.digitos_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq[4]  = '{4'h3, 4'hB, 4'h4, 4'hB};
    logic       strb[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    foreach (seq[i]) begin
      apply(1'b0, 1'b1, seq[i]);
      vectors++;
      if (bus.digitos_valid !== strb[i] || bus.digitos_value !== exp_value) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: valid=%b value=%h, expected valid=%b value=%h",
                 i, bus.digitos_valid, bus.digitos_value, strb[i], exp_value);
      end
    end
  endtask

`ifdef MONTADOR_TIMEOUT_EN
  task automatic test_timeout();
    apply(1'b1, 1'b0, 4'h0);
    apply(1'b0, 1'b1, 4'h9);
    for (int i = 0; i < 10; i++) apply(1'b0, 1'b0, 4'h0);
    apply(1'b0, 1'b1, 4'hB);
    vectors++;
    if (bus.digitos_valid !== 1'b0 || bus.digitos_value !== {80{1'b1}}) begin
      miscompares++;
      $display("FAIL timeout_expired: valid=%b value=%h, expected valid=0 value=%h",
               bus.digitos_valid, bus.digitos_value, {80{1'b1}});
    end
    apply(1'b0, 1'b1, 4'h9);
    for (int i = 0; i < 9; i++) apply(1'b0, 1'b0, 4'h0);
    apply(1'b0, 1'b1, 4'hB);
    vectors++;
    if (bus.digitos_valid !== 1'b1 || bus.digitos_value !== 80'hFFFF_FFFF_FFFF_FFFF_FFF9) begin
      miscompares++;
      $display("FAIL timeout_edge: valid=%b value=%h, expected valid=1 value=%h",
               bus.digitos_valid, bus.digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FFF9);
    end
  endtask
`endif

  task automatic test_random();
    logic       r, v;
    logic [3:0] k;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) == 0);
      k = 4'($urandom_range(0, 15));
      apply(r, v, k);
      vectors++;
      if (bus.digitos_valid !== exp_valid || bus.digitos_value !== exp_value) begin
        miscompares++;
        $display("FAIL random[%0d]: valid=%b value=%h, expected valid=%b value=%h",
                 n, bus.digitos_valid, bus.digitos_value, exp_valid, exp_value);
      end
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_value = 4'h0;
    exp_value     = '1;
    exp_valid     = 1'b0;
    idle          = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_clear();
    test_overflow();
    test_ignored();
    test_reset_collision();
    test_back_to_back();
`ifdef MONTADOR_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
